// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: condition codes, condition-unit FSM states
// and bit positions of the {N,Z,C,V} flag register.
package cpu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        VALID = 2'd2
    } cond_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Controller <-> condition unit bus: ALU flags in, req/valid/ack handshake,
// registered condex result and the current flag register.
interface cond_unit_if;

    logic       alu_n;
    logic       alu_z;
    logic       alu_c;
    logic       alu_v;
    logic [1:0] flag_write;
    logic [3:0] cond;
    logic       cond_req;
    logic       cond_ack;
    logic       cond_busy;
    logic       cond_valid;
    logic       condex;
    logic [3:0] flags;

    modport master (
        output alu_n, alu_z, alu_c, alu_v, flag_write, cond, cond_req, cond_ack,
        input  cond_busy, cond_valid, condex, flags
    );

    modport slave (
        input  alu_n, alu_z, alu_c, alu_v, flag_write, cond, cond_req, cond_ack,
        output cond_busy, cond_valid, condex, flags
    );

endinterface

// File: rtl/cond_unit_check.sv
// Combinational condition-code evaluator: result is 1 when 'cond' holds
// for the given {N,Z,C,V} flags. Also usable by the controller's assertions.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       result
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        result = 1'b1;
        case (cond_e'(cond))
            COND_EQ: result = z;
            COND_NE: result = !z;
            COND_CS: result = c;
            COND_CC: result = !c;
            COND_MI: result = n;
            COND_PL: result = !n;
            COND_VS: result = v;
            COND_VC: result = !v;
            COND_HI: result = c & !z;
            COND_LS: result = !c | z;
            COND_GE: result = (n == v);
            COND_LT: result = (n != v);
            COND_GT: result = !z & (n == v);
            COND_LE: result = z | (n != v);
            COND_AL: result = 1'b1;
            COND_NV: result = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: NZCV flag register plus IDLE/EVAL/VALID evaluation FSM.
// Define COND_UNIT_STATS_EN to add saturating stat_eval/stat_taken counters.
module cond_unit
    import cpu_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
`ifdef COND_UNIT_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    cond_unit_if.slave        bus
`ifdef COND_UNIT_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_eval,
    output logic [STAT_W-1:0] stat_taken
`endif
);

    cond_state_e state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic [3:0]  cond_q, cond_d;
    logic        condex_q, condex_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        eval_result;

    cond_check u_check (
        .cond   (cond_q),
        .flags  (flags_q),
        .result (eval_result)
    );

    // Flag writes run independently of the FSM; EVAL reads flags_q, so a
    // write issued during EVAL lands only after this result is captured.
    always_comb begin
        flags_d = flags_q;
        if (bus.flag_write[1]) begin
            flags_d[FLAG_N] = bus.alu_n;
            flags_d[FLAG_Z] = bus.alu_z;
        end
        if (bus.flag_write[0]) begin
            flags_d[FLAG_C] = bus.alu_c;
            flags_d[FLAG_V] = bus.alu_v;
        end
    end

    always_comb begin
        state_d  = state_q;
        cond_d   = cond_q;
        condex_d = condex_q;
        case (state_q)
            IDLE: begin
                if (bus.cond_req) begin
                    cond_d  = bus.cond;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                condex_d = eval_result;
                state_d  = VALID;
            end
            VALID: begin
                if (bus.cond_ack) begin
                    if (bus.cond_req) begin
                        cond_d  = bus.cond;
                        state_d = EVAL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d == EVAL);
        valid_d = (state_d == VALID);
    end

`ifdef COND_UNIT_STATS_EN
    logic [STAT_W-1:0] stat_eval_q, stat_eval_d;
    logic [STAT_W-1:0] stat_taken_q, stat_taken_d;

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        stat_eval_d  = stat_eval_q;
        stat_taken_d = stat_taken_q;
        if (state_q == EVAL) begin
            if (stat_eval_q != '1) begin
                stat_eval_d = stat_eval_q + 1'b1;
            end
            if (eval_result && (stat_taken_q != '1)) begin
                stat_taken_d = stat_taken_q + 1'b1;
            end
        end
    end

    assign stat_eval  = stat_eval_q;
    assign stat_taken = stat_taken_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            flags_q      <= RESET_FLAGS;
            cond_q       <= 4'b0000;
            condex_q     <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
`ifdef COND_UNIT_STATS_EN
            stat_eval_q  <= '0;
            stat_taken_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            cond_q       <= cond_d;
            condex_q     <= condex_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
`ifdef COND_UNIT_STATS_EN
            stat_eval_q  <= stat_eval_d;
            stat_taken_q <= stat_taken_d;
`endif
        end
    end

    assign bus.flags      = flags_q;
    assign bus.condex     = condex_q;
    assign bus.cond_busy  = busy_q;
    assign bus.cond_valid = valid_q;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus pushes hand-computed condex values,
// a negedge monitor pops and compares each time cond_valid rises.
module tb_cond_unit;

    import cpu_pkg::*;

    logic clk;
    logic rst_n;

    cond_unit_if bus ();

`ifdef COND_UNIT_STATS_EN
    logic [1:0] stat_eval;
    logic [1:0] stat_taken;

    cond_unit #(
        .RESET_FLAGS (4'b0000),
        .STAT_W      (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .stat_eval  (stat_eval),
        .stat_taken (stat_taken)
    );
`else
    cond_unit #(
        .RESET_FLAGS (4'b0000)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] exp_q[$];
    logic       prev_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check_output(string name, logic [3:0] actual, logic [3:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Monitor: every fresh cond_valid presentation consumes one expected result.
    initial begin
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.cond_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_result: got condex %b, expected no result", bus.condex);
                end else begin
                    check_output("condex", {3'b000, bus.condex}, exp_q.pop_front());
                end
            end
            prev_valid = bus.cond_valid;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] wr, input logic [3:0] nzcv);
        bus.flag_write = wr;
        {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = nzcv;
        next_cycle();
        bus.flag_write = 2'b00;
    endtask

    // Issue a request from IDLE and stop in VALID without acknowledging.
    task automatic enter_valid(input logic [3:0] code, input logic expected);
        exp_q.push_back({3'b000, expected});
        bus.cond     = code;
        bus.cond_req = 1'b1;
        next_cycle();
        bus.cond_req = 1'b0;
        check_output("busy_in_eval", {3'b000, bus.cond_busy}, 4'd1);
        next_cycle();
        check_output("valid_at_k2", {3'b000, bus.cond_valid}, 4'd1);
    endtask

    task automatic evaluate(input logic [3:0] code, input logic expected);
        enter_valid(code, expected);
        bus.cond_ack = 1'b1;
        next_cycle();
        bus.cond_ack = 1'b0;
    endtask

    typedef struct {
        logic [3:0] code;
        logic       expected;
    } vec_t;

    // Decode table for flags N=1 Z=1 C=0 V=0.
    vec_t decode_vecs[16] = '{
        '{4'h0, 1'b1}, '{4'h1, 1'b0}, '{4'h2, 1'b0}, '{4'h3, 1'b1},
        '{4'h4, 1'b1}, '{4'h5, 1'b0}, '{4'h6, 1'b0}, '{4'h7, 1'b1},
        '{4'h8, 1'b0}, '{4'h9, 1'b1}, '{4'hA, 1'b0}, '{4'hB, 1'b1},
        '{4'hC, 1'b0}, '{4'hD, 1'b1}, '{4'hE, 1'b1}, '{4'hF, 1'b1}
    };

    initial begin
        rst_n          = 1'b1;
        bus.alu_n      = 1'b0;
        bus.alu_z      = 1'b0;
        bus.alu_c      = 1'b0;
        bus.alu_v      = 1'b0;
        bus.flag_write = 2'b00;
        bus.cond       = 4'h0;
        bus.cond_req   = 1'b0;
        bus.cond_ack   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_output("reset_flags", bus.flags, 4'b0000);
        check_output("reset_valid", {3'b000, bus.cond_valid}, 4'd0);
        check_output("reset_busy", {3'b000, bus.cond_busy}, 4'd0);
        check_output("reset_condex", {3'b000, bus.condex}, 4'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Split write: NZ from 1111, then CV from 0000
        apply_stimulus(2'b10, 4'b1111);
        check_output("split_nz", bus.flags, 4'b1100);
        apply_stimulus(2'b01, 4'b0000);
        check_output("split_cv", bus.flags, 4'b1100);
        apply_stimulus(2'b00, 4'b0011);
        check_output("hold_flags", bus.flags, 4'b1100);

        foreach (decode_vecs[i]) begin
            evaluate(decode_vecs[i].code, decode_vecs[i].expected);
        end

        // Signed compare with N=1 Z=0 C=0 V=1
        apply_stimulus(2'b11, 4'b1001);
        check_output("signed_flags", bus.flags, 4'b1001);
        evaluate(4'hA, 1'b1);
        evaluate(4'hC, 1'b1);
        evaluate(4'hB, 1'b0);

        // Flag write during EVAL must not affect this result
        exp_q.push_back(4'd0);
        bus.cond     = 4'h0;
        bus.cond_req = 1'b1;
        next_cycle();
        bus.cond_req   = 1'b0;
        bus.flag_write = 2'b10;
        bus.alu_n      = 1'b1;
        bus.alu_z      = 1'b1;
        next_cycle();
        bus.flag_write = 2'b00;
        check_output("eval_write_valid", {3'b000, bus.cond_valid}, 4'd1);
        check_output("eval_write_flags", bus.flags, 4'b1101);
        bus.cond_ack = 1'b1;
        next_cycle();
        bus.cond_ack = 1'b0;
        check_output("ack_to_idle", {3'b000, bus.cond_valid}, 4'd0);

        // Back-to-back: NE with Z=1 gives 0, then AL gives 1
        enter_valid(4'h1, 1'b0);
        exp_q.push_back(4'd1);
        bus.cond_ack = 1'b1;
        bus.cond_req = 1'b1;
        bus.cond     = 4'hE;
        next_cycle();
        bus.cond_ack = 1'b0;
        bus.cond_req = 1'b0;
        check_output("b2b_busy", {3'b000, bus.cond_busy}, 4'd1);
        check_output("b2b_valid_low", {3'b000, bus.cond_valid}, 4'd0);
        next_cycle();
        check_output("b2b_valid", {3'b000, bus.cond_valid}, 4'd1);
        bus.cond_ack = 1'b1;
        next_cycle();
        bus.cond_ack = 1'b0;

        // Reset mid-VALID clears outputs asynchronously
        apply_stimulus(2'b11, 4'b0100);
        enter_valid(4'h0, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("rst_mid_valid", {3'b000, bus.cond_valid}, 4'd0);
        check_output("rst_mid_condex", {3'b000, bus.condex}, 4'd0);
        check_output("rst_mid_flags", bus.flags, 4'b0000);
        check_output("rst_mid_busy", {3'b000, bus.cond_busy}, 4'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

`ifdef COND_UNIT_STATS_EN
        check_output("stat_eval_reset", {2'b00, stat_eval}, 4'd0);
        evaluate(4'hE, 1'b1);
        evaluate(4'hE, 1'b1);
        check_output("stat_eval_2", {2'b00, stat_eval}, 4'd2);
        check_output("stat_taken_2", {2'b00, stat_taken}, 4'd2);
        evaluate(4'hE, 1'b1);
        evaluate(4'hE, 1'b1);
        evaluate(4'hE, 1'b1);
        check_output("stat_eval_sat", {2'b00, stat_eval}, 4'd3);
        check_output("stat_taken_sat", {2'b00, stat_taken}, 4'd3);
`endif

        next_cycle();
        next_cycle();
        check_output("scoreboard_empty", exp_q.size() == 0 ? 4'd0 : 4'd1, 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
